pixel_word_packer: RTL and testbench

Collects 8-bit sharpened pixels from the filter datapath and packs them into 32-bit words for write-back to DLX data memory. It is the write-side counterpart of the 16-bit input data buffer. It owns the write address counter and issues one word write per four pixels, or a partial word on flush. It sits between the sharpening filter output and the memory write port of the extension.

---
 rtl/pixel_pack_pkg.sv | 13 +
 rtl/pack_addr_counter.sv | 50 +++++
 rtl/pixel_word_packer.sv | 149 ++++++++++++++
 tb/tb_pixel_word_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pack_pkg.sv
// Shared constants for the pixel word packer: FSM encoding and default geometry.
package pixel_pack_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int LANES_DEF  = 4;
  localparam int ADDR_W_DEF = 16;
  localparam int WORD_W     = PIX_W_DEF * LANES_DEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/pack_addr_counter.sv
// Write address counter (load / step by one word, wrapping) and the
// saturating count of words written since the last load.
module pack_addr_counter
  import pixel_pack_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       word_cnt
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;

  // Next address and count; the address add wraps naturally at ADDR_W bits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = base_addr;
      cnt_d  = '0;
    end else if (inc) begin
      addr_d = addr_q + ADDR_W'(LANES);
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr     = addr_q;
  assign word_cnt = cnt_q;

endmodule

// File: rtl/pixel_word_packer.sv
// Packs PIX_W-bit pixels big-endian into PIX_W*LANES-bit words and issues
// one memory write per full word, or a partial word on FLUSH.
module pixel_word_packer
  import pixel_pack_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic [ADDR_W-1:0]      BASE_ADDR,
  input  logic [PIX_W-1:0]       PIX_IN,
  input  logic                   PIX_VALID,
  output logic                   PIX_READY,
  input  logic                   FLUSH,
  output logic                   WR_REQ,
  input  logic                   WR_ACK,
  output logic [PIX_W*LANES-1:0] WR_D,
  output logic [LANES-1:0]       WR_BE,
  output logic [ADDR_W-1:0]      WR_ADDR,
  output logic                   BUSY,
  output logic [15:0]            WORD_CNT
);

  localparam int WW     = PIX_W * LANES;
  localparam int LANE_W = $clog2(LANES + 1);

  logic [1:0]        state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d, lane_after;
  logic [WW-1:0]     wr_d_q, wr_d_d;
  logic [LANES-1:0]  wr_be_q, wr_be_d;
  logic              flush_pend_q, flush_pend_d;
  logic              wr_req_q, wr_req_d;
  logic              pix_ready_q, pix_ready_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              cnt_load, cnt_inc;

  assign accept     = PIX_VALID && pix_ready_q;
  assign lane_after = lane_q + LANE_W'(accept);

  // FSM, lane merge and flush bookkeeping; outputs are registered from the next state.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    wr_d_d       = wr_d_q;
    wr_be_d      = wr_be_q;
    flush_pend_d = flush_pend_q;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;

    if (START) begin
      state_d      = ST_FILL;
      lane_d       = '0;
      wr_d_d       = '0;
      wr_be_d      = '0;
      flush_pend_d = 1'b0;
      cnt_load     = 1'b1;
    end else begin
      case (state_q)
        ST_FILL: begin
          for (int i = 0; i < LANES; i++) begin
            if (accept && lane_q == LANE_W'(i)) begin
              wr_d_d[WW-1-i*PIX_W -: PIX_W] = PIX_IN;
              wr_be_d[LANES-1-i]            = 1'b1;
            end
          end
          lane_d = lane_after;
          if (lane_after == LANE_W'(LANES)) state_d = ST_WRITE;
          if (FLUSH) begin
            if (lane_after != '0) begin
              state_d      = ST_WRITE;
              flush_pend_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          if (FLUSH) flush_pend_d = 1'b1;
          if (WR_ACK) begin
            cnt_inc = 1'b1;
            lane_d  = '0;
            wr_d_d  = '0;
            wr_be_d = '0;
            if (flush_pend_q || FLUSH) begin
              state_d      = ST_IDLE;
              flush_pend_d = 1'b0;
            end else begin
              state_d = ST_FILL;
            end
          end
        end
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    wr_req_d    = (state_d == ST_WRITE);
    pix_ready_d = (state_d == ST_FILL);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous: RESET_N is only sampled at the clock edge, never in the sensitivity list.
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      lane_q       <= '0;
      wr_d_q       <= '0;
      wr_be_q      <= '0;
      flush_pend_q <= 1'b0;
      wr_req_q     <= 1'b0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      wr_d_q       <= wr_d_d;
      wr_be_q      <= wr_be_d;
      flush_pend_q <= flush_pend_d;
      wr_req_q     <= wr_req_d;
      pix_ready_q  <= pix_ready_d;
      busy_q       <= busy_d;
    end
  end

  pack_addr_counter #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_addr (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (cnt_load),
    .base_addr (BASE_ADDR),
    .inc       (cnt_inc),
    .addr      (WR_ADDR),
    .word_cnt  (WORD_CNT)
  );

  assign WR_REQ    = wr_req_q;
  assign PIX_READY = pix_ready_q;
  assign BUSY      = busy_q;
  assign WR_D      = wr_d_q;
  assign WR_BE     = wr_be_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer with hand-computed expected words.
module tb_pixel_word_packer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] BASE_ADDR = '0;
  logic [7:0]  PIX_IN = '0;
  logic        PIX_VALID = 1'b0;
  logic        PIX_READY;
  logic        FLUSH = 1'b0;
  logic        WR_REQ;
  logic        WR_ACK = 1'b0;
  logic [31:0] WR_D;
  logic [3:0]  WR_BE;
  logic [15:0] WR_ADDR;
  logic        BUSY;
  logic [15:0] WORD_CNT;

  int errors = 0;
  int checks = 0;

  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_be[$];

  pixel_word_packer dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .BASE_ADDR (BASE_ADDR),
    .PIX_IN    (PIX_IN),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .FLUSH     (FLUSH),
    .WR_REQ    (WR_REQ),
    .WR_ACK    (WR_ACK),
    .WR_D      (WR_D),
    .WR_BE     (WR_BE),
    .WR_ADDR   (WR_ADDR),
    .BUSY      (BUSY),
    .WORD_CNT  (WORD_CNT)
  );

  always #5 CLK = ~CLK;

  // Record every write the memory accepts (values are stable mid-cycle).
  always @(negedge CLK) begin
    if (RESET_N && WR_REQ && WR_ACK) begin
      wq_addr.push_back(WR_ADDR);
      wq_data.push_back(WR_D);
      wq_be.push_back(WR_BE);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_at(input logic [15:0] a);
    START     = 1'b1;
    BASE_ADDR = a;
    tick();
    START     = 1'b0;
  endtask

  // Offer one pixel and hold it until the edge that accepts it.
  task automatic send_pixel(input logic [7:0] p);
    bit acc = 0;
    PIX_IN    = p;
    PIX_VALID = 1'b1;
    for (int n = 0; n < 40 && !acc; n++) begin
      if (PIX_READY) acc = 1;
      tick();
    end
    PIX_VALID = 1'b0;
    if (!acc) check("pixel_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset with random inputs.
    for (int c = 0; c < 2; c++) begin
      START = 1'($urandom); FLUSH = 1'($urandom); PIX_VALID = 1'($urandom);
      WR_ACK = 1'($urandom); PIX_IN = 8'($urandom); BASE_ADDR = 16'($urandom);
      tick();
    end
    check("rst_wr_req", 32'(WR_REQ), 32'd0);
    check("rst_wr_d", WR_D, 32'd0);
    check("rst_wr_be", 32'(WR_BE), 32'd0);
    check("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    check("rst_pix_ready", 32'(PIX_READY), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_word_cnt", 32'(WORD_CNT), 32'd0);
    START = 0; FLUSH = 0; PIX_VALID = 0; WR_ACK = 0;
    RESET_N = 1'b1;
    tick();
    check("idle_ready", 32'(PIX_READY), 32'd0);

    // Two full words with ACK tied high.
    WR_ACK = 1'b1;
    start_at(16'h0100);
    check("fill_ready", 32'(PIX_READY), 32'd1);
    check("fill_busy", 32'(BUSY), 32'd1);
    send_pixel(8'h11); send_pixel(8'h22); send_pixel(8'h33);
    check("req_before_4th", 32'(WR_REQ), 32'd0);
    send_pixel(8'h44);
    check("req_after_4th", 32'(WR_REQ), 32'd1);
    check("w0_ready_low", 32'(PIX_READY), 32'd0);
    send_pixel(8'h55); send_pixel(8'h66); send_pixel(8'h77); send_pixel(8'h88);
    tick();
    check("full_cnt", 32'(WORD_CNT), 32'd2);
    check("full_nwords", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      check("w0_data", wq_data[0], 32'h11223344);
      check("w0_addr", 32'(wq_addr[0]), 32'h0100);
      check("w0_be", 32'(wq_be[0]), 32'hF);
      check("w1_data", wq_data[1], 32'h55667788);
      check("w1_addr", 32'(wq_addr[1]), 32'h0104);
      check("w1_be", 32'(wq_be[1]), 32'hF);
    end
    check("fill_again_ready", 32'(PIX_READY), 32'd1);

    // Partial word on FLUSH.
    start_at(16'h0300);
    send_pixel(8'hAA); send_pixel(8'hBB);
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
    check("part_req", 32'(WR_REQ), 32'd1);
    check("part_data", WR_D, 32'hAABB0000);
    check("part_be", 32'(WR_BE), 32'hC);
    check("part_addr", 32'(WR_ADDR), 32'h0300);
    tick();
    check("part_idle_busy", 32'(BUSY), 32'd0);
    check("part_idle_ready", 32'(PIX_READY), 32'd0);
    check("part_idle_req", 32'(WR_REQ), 32'd0);
    check("part_cnt", 32'(WORD_CNT), 32'd1);

    // FLUSH with no pixels: back to IDLE, no write.
    wq_addr.delete(); wq_data.delete(); wq_be.delete();
    start_at(16'h0380);
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
    tick(); tick();
    check("empty_flush_busy", 32'(BUSY), 32'd0);
    check("empty_flush_req", 32'(WR_REQ), 32'd0);
    check("empty_flush_nwords", wq_addr.size(), 32'd0);

    // START and FLUSH together: START wins.
    START = 1'b1; FLUSH = 1'b1; BASE_ADDR = 16'h0390; tick();
    START = 1'b0; FLUSH = 1'b0;
    check("start_flush_busy", 32'(BUSY), 32'd1);
    check("start_flush_ready", 32'(PIX_READY), 32'd1);

    // Backpressure: ACK low for five cycles.
    WR_ACK = 1'b0;
    start_at(16'h0400);
    send_pixel(8'h01); send_pixel(8'h02); send_pixel(8'h03); send_pixel(8'h04);
    PIX_IN = 8'h05; PIX_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_req", 32'(WR_REQ), 32'd1);
      check("bp_data", WR_D, 32'h01020304);
      check("bp_addr", 32'(WR_ADDR), 32'h0400);
      check("bp_ready", 32'(PIX_READY), 32'd0);
      tick();
    end
    WR_ACK = 1'b1;
    tick();
    check("bp_ack_req", 32'(WR_REQ), 32'd0);
    check("bp_ack_ready", 32'(PIX_READY), 32'd1);
    check("bp_not_taken_early", 32'(WR_BE), 32'd0);
    check("bp_cnt", 32'(WORD_CNT), 32'd1);
    check("bp_next_addr", 32'(WR_ADDR), 32'h0404);
    tick();
    PIX_VALID = 1'b0;
    check("bp_next_be", 32'(WR_BE), 32'h8);
    check("bp_next_data", WR_D, 32'h05000000);
    FLUSH = 1'b1; tick(); FLUSH = 1'b0;
    tick();
    check("bp_flush_idle", 32'(BUSY), 32'd0);

    // Address wrap.
    wq_addr.delete(); wq_data.delete(); wq_be.delete();
    start_at(16'hFFFC);
    for (int k = 0; k < 8; k++) send_pixel(8'(8'hD0 + k));
    tick();
    check("wrap_nwords", wq_addr.size(), 32'd2);
    if (wq_addr.size() == 2) begin
      check("wrap_a0", 32'(wq_addr[0]), 32'hFFFC);
      check("wrap_a1", 32'(wq_addr[1]), 32'h0000);
      check("wrap_d0", wq_data[0], 32'hD0D1D2D3);
      check("wrap_d1", wq_data[1], 32'hD4D5D6D7);
    end
    check("wrap_next_addr", 32'(WR_ADDR), 32'h0004);

    // Abort a pending write with START.
    WR_ACK = 1'b0;
    start_at(16'h0500);
    send_pixel(8'hE0); send_pixel(8'hE1); send_pixel(8'hE2); send_pixel(8'hE3);
    check("abort_pre_req", 32'(WR_REQ), 32'd1);
    start_at(16'h0200);
    check("abort_req", 32'(WR_REQ), 32'd0);
    check("abort_be", 32'(WR_BE), 32'd0);
    check("abort_data", WR_D, 32'd0);
    check("abort_cnt", 32'(WORD_CNT), 32'd0);
    check("abort_addr", 32'(WR_ADDR), 32'h0200);
    check("abort_ready", 32'(PIX_READY), 32'd1);
    wq_addr.delete(); wq_data.delete(); wq_be.delete();
    WR_ACK = 1'b1;
    send_pixel(8'hC1); send_pixel(8'hC2); send_pixel(8'hC3); send_pixel(8'hC4);
    tick();
    check("abort_nwords", wq_addr.size(), 32'd1);
    if (wq_addr.size() == 1) begin
      check("abort_w_addr", 32'(wq_addr[0]), 32'h0200);
      check("abort_w_data", wq_data[0], 32'hC1C2C3C4);
    end
    check("abort_w_cnt", 32'(WORD_CNT), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
